fetch_queue: RTL

- Instruction buffer between the fetch stage (fetch_out_ifc producer) and the decode stage.
- Decouples fetch from decode back-pressure by holding up to DEPTH fetched instructions with their branch-prediction metadata, in program order.
- Drains in order to decode.
- Flushes completely on a branch misprediction redirect (branch_fb_decode_ifc: if_branch && !if_prediction_correct).

---
 rtl/fetch_queue.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode, carrying branch-prediction
// metadata. It flushes completely when decode reports a mispredicted branch.
module fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       in_guesses_branch,
  input  logic [ADDR_W-1:0]          in_prediction,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_guesses_branch,
  output logic [ADDR_W-1:0]          out_prediction,
  input  logic                       out_ready,
  input  logic                       fb_if_branch,
  input  logic                       fb_if_prediction_correct,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic              guesses_branch;
    logic [ADDR_W-1:0] prediction;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            head_entry;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              flush, push, pop;

  assign flush     = fb_if_branch && !fb_if_prediction_correct;
  assign in_ready  = (count_q < CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  // Empty queue presents zeros rather than stale storage.
  assign head_entry         = out_valid ? mem_q[head_q] : '0;
  assign out_pc             = head_entry.pc;
  assign out_instr          = head_entry.instr;
  assign out_guesses_branch = head_entry.guesses_branch;
  assign out_prediction     = head_entry.prediction;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_ONE;
      if (pop)  head_d = head_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{pc: in_pc, instr: in_instr, guesses_branch: in_guesses_branch,
                         prediction: in_prediction};
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!n_rst) count_q <= CNT_FULL);
  a_empty_ptrs:  assert property (@(posedge clk) disable iff (!n_rst)
                                  (count_q == '0) |-> (head_q == tail_q));
  a_full_ptrs:   assert property (@(posedge clk) disable iff (!n_rst)
                                  (count_q == CNT_FULL) |-> (head_q == tail_q));

endmodule
